nearest_hit_reduce: RTL and testbench
=====================================

NEAREST_HIT_REDUCE -- requirements
Module: nearest_hit_reduce

Interface
REQ-001 SHALL have parameter SIZE, default 32, float word width; only IEEE single (32) is supported.
REQ-002 SHALL have parameter NUM_OBJS, default 16, maximum candidates per ray, range 2..64.
REQ-003 SHALL have parameter T_MIN, default 32'h3a83126f (1e-3), self-intersection epsilon.
REQ-004 SHALL have parameter ANY_HIT, default 0; 0 = closest hit, 1 = first valid hit (shadow rays).
REQ-005 SHALL have localparam IDX_W = $clog2(NUM_OBJS+1); NO_HIT = NUM_OBJS.
REQ-006 aclk  in  1  sole clock; all logic on rising edge.
REQ-007 areset  in  1  synchronous, active-high reset.
REQ-008 cand_axis_tdata  in  SIZE  candidate t.
REQ-009 cand_axis_tpayload  in  6*SIZE  {normal, hit_point}.
REQ-010 cand_axis_tidx  in  IDX_W  object index.
REQ-011 cand_axis_tmiss  in  1  upstream reports no intersection.
REQ-012 cand_axis_tlast  in  1  final candidate of current ray.
REQ-013 cand_axis_thcount / cand_axis_tvcount  in  11 / 10  pixel tag.
REQ-014 cand_axis_tvalid in 1; cand_axis_tready out 1.
REQ-015 hit_axis_tdata  out  6*SIZE  winning payload.
REQ-016 hit_axis_tt  out  SIZE  winning t; hit_axis_tidx  out  IDX_W; hit_axis_thit  out  1.
REQ-017 hit_axis_thcount / hit_axis_tvcount  out  11 / 10.
REQ-018 hit_axis_tvalid out 1; hit_axis_tready in 1.
REQ-019 err_overlong  out  1  sticky protocol error.

Function
REQ-020 Beat accepted iff cand_axis_tvalid && cand_axis_tready; cand_axis_tready SHALL equal !hit_axis_tvalid || hit_axis_tready.
REQ-021 States: IDLE (no ray open), ACCUM (ray open); IDLE->ACCUM on accepted non-last beat; ACCUM->IDLE on accepted tlast beat; single-beat ray stays IDLE.
REQ-022 Candidate valid iff !tmiss, sign bit 0, exponent != 8'hFF, tidx < NUM_OBJS, and t > T_MIN.
REQ-023 Comparison SHALL be unsigned compare of t bit patterns (valid only for non-negative finite floats); no float IP.
REQ-024 Closest mode: running best replaced only when candidate valid and t strictly less than best; ties keep earlier beat.
REQ-025 Any-hit mode: first valid candidate of ray latched; later beats consumed and ignored.
REQ-026 First beat of a ray SHALL compare against FLOAT_MAX (32'h7f7fffff), not the previous ray's best.
REQ-027 On accepted tlast beat, result (including that beat) SHALL load output register; hit_axis_tvalid high on next cycle (latency 1).
REQ-028 Pixel tag SHALL be taken from the tlast beat.
REQ-029 No valid candidate: thit=0, tidx=NO_HIT, tt=FLOAT_MAX, tdata=0.
REQ-030 Output held stable while hit_axis_tvalid && !hit_axis_tready.
REQ-031 Simultaneous output handshake and tlast acceptance SHALL reload output back-to-back; sustained throughput one ray per cycle for single-beat rays.
REQ-032 Beat counter SHALL count beats per ray; the NUM_OBJS-th beat without tlast SHALL be treated as tlast, emit result, set err_overlong.
REQ-033 err_overlong cleared only by reset.

Reset
REQ-034 During areset: hit_axis_tvalid=0, all hit_axis_* data 0, err_overlong=0, state IDLE, beat counter 0, best=FLOAT_MAX.
REQ-035 Reset mid-ray or with output pending SHALL discard partial ray and pending result; cand_axis_tready=1 first cycle after reset.

Structure
REQ-036 FLOAT_MAX, T_MIN default, and function float_is_valid_pos SHALL live in shared package rt_pkg.
REQ-037 Output register with hold SHALL be sub-module axis_out_reg, parametrised by width.

Verification
REQ-038 Closest: t={4.0,2.0,3.0}, idx 0..2, tlast on third, tready=1 -> one output tidx=1, tt=32'h40000000, thit=1, one cycle after tlast.
REQ-039 Filters: t={-1.0, 5e-4, +Inf, NaN} plus miss beat -> thit=0, tidx=NUM_OBJS, tt=32'h7f7fffff.
REQ-040 Backpressure: two 2-beat rays, hit_axis_tready low 5 cycles -> cand_axis_tready low on second tlast until drain; both results correct, in order, payload stable.
REQ-041 Any-hit (ANY_HIT=1): t={6.0,2.0}, idx {3,7} -> tidx=3, tt=32'h40c00000.
REQ-042 Overlong: NUM_OBJS=4, 5 beats no tlast -> result after beat 4, err_overlong=1; beat 5 opens new ray.
REQ-043 Reset mid-ray after 2 of 3 beats, then fresh 1-beat ray t=1.0 idx 5 -> single output tidx=5, no stale result.

Source files
------------

// File: rtl/rt_pkg.sv
// Shared ray-tracing constants and float helpers used by the hit reduction logic.
package rt_pkg;
  localparam logic [31:0] FLOAT_MAX     = 32'h7f7fffff;
  localparam logic [31:0] T_MIN_DEFAULT = 32'h3a83126f;

  typedef enum logic {IDLE, ACCUM} ray_state_t;

  // Non-negative finite floats order the same way as their bit patterns.
  function automatic logic float_is_valid_pos(input logic [31:0] t, input logic [31:0] t_min);
    return !t[31] && (t[30:23] != 8'hFF) && (t > t_min);
  endfunction
endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-stream output register: loads on demand, holds data while stalled.
module axis_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);
  // The caller only loads when the slot is empty or draining this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/nearest_hit_reduce.sv
// Reduces a stream of per-object ray candidates to one nearest (or first) hit per ray.
module nearest_hit_reduce
  import rt_pkg::*;
#(
  parameter int          SIZE     = 32,
  parameter int          NUM_OBJS = 16,
  parameter logic [31:0] T_MIN    = 32'h3a83126f,
  parameter bit          ANY_HIT  = 1'b0,
  localparam int         IDX_W    = $clog2(NUM_OBJS+1),
  localparam int         NO_HIT   = NUM_OBJS
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [SIZE-1:0]   cand_axis_tdata,
  input  logic [6*SIZE-1:0] cand_axis_tpayload,
  input  logic [IDX_W-1:0]  cand_axis_tidx,
  input  logic              cand_axis_tmiss,
  input  logic              cand_axis_tlast,
  input  logic [10:0]       cand_axis_thcount,
  input  logic [9:0]        cand_axis_tvcount,
  input  logic              cand_axis_tvalid,
  output logic              cand_axis_tready,
  output logic [6*SIZE-1:0] hit_axis_tdata,
  output logic [SIZE-1:0]   hit_axis_tt,
  output logic [IDX_W-1:0]  hit_axis_tidx,
  output logic              hit_axis_thit,
  output logic [10:0]       hit_axis_thcount,
  output logic [9:0]        hit_axis_tvcount,
  output logic              hit_axis_tvalid,
  input  logic              hit_axis_tready,
  output logic              err_overlong
);
  localparam int PAY_W = 6*SIZE;
  localparam int CNT_W = $clog2(NUM_OBJS);
  localparam int OUT_W = PAY_W + SIZE + IDX_W + 1 + 21;
  localparam logic [IDX_W-1:0] NO_HIT_IDX = IDX_W'(NO_HIT);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(NUM_OBJS-1);

  ray_state_t       state, state_nxt;
  logic [SIZE-1:0]  best_t, base_t, new_t;
  logic [IDX_W-1:0] best_idx, base_idx, new_idx;
  logic [PAY_W-1:0] best_pay, base_pay, new_pay;
  logic             best_found, base_found, new_found;
  logic [CNT_W-1:0] beat_cnt;
  logic             accept, cand_ok, take, ray_end, overlong;
  logic [OUT_W-1:0] out_load, out_data;

  assign cand_axis_tready = !hit_axis_tvalid || hit_axis_tready;
  assign accept   = cand_axis_tvalid && cand_axis_tready;
  assign cand_ok  = !cand_axis_tmiss && (cand_axis_tidx < NO_HIT_IDX) &&
                    float_is_valid_pos(cand_axis_tdata, T_MIN);
  assign overlong = !cand_axis_tlast && (beat_cnt == CNT_LAST);
  assign ray_end  = cand_axis_tlast || overlong;

  always_comb begin
    base_t     = FLOAT_MAX;
    base_idx   = NO_HIT_IDX;
    base_pay   = '0;
    base_found = 1'b0;
    // A fresh ray never sees the previous ray's best.
    if (state == ACCUM) begin
      base_t     = best_t;
      base_idx   = best_idx;
      base_pay   = best_pay;
      base_found = best_found;
    end
    take      = cand_ok && (ANY_HIT ? !base_found : (cand_axis_tdata < base_t));
    new_t     = take ? cand_axis_tdata : base_t;
    new_idx   = take ? cand_axis_tidx : base_idx;
    new_pay   = take ? cand_axis_tpayload : base_pay;
    new_found = take || base_found;
  end

  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = ray_end ? IDLE : ACCUM;
  end

  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge aclk) begin
    if (areset || (accept && ray_end)) begin
      beat_cnt   <= '0;
      best_t     <= FLOAT_MAX;
      best_idx   <= NO_HIT_IDX;
      best_pay   <= '0;
      best_found <= 1'b0;
    end else if (accept) begin
      beat_cnt   <= beat_cnt + 1'b1;
      best_t     <= new_t;
      best_idx   <= new_idx;
      best_pay   <= new_pay;
      best_found <= new_found;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset)                  err_overlong <= 1'b0;
    else if (accept && overlong) err_overlong <= 1'b1;
  end

  assign out_load = {new_pay, new_t, new_idx, new_found, cand_axis_thcount, cand_axis_tvcount};

  axis_out_reg #(.W(OUT_W)) u_out (
    .clk       (aclk),
    .rst       (areset),
    .load      (accept && ray_end),
    .load_data (out_load),
    .ready     (hit_axis_tready),
    .valid     (hit_axis_tvalid),
    .data      (out_data)
  );

  assign {hit_axis_tdata, hit_axis_tt, hit_axis_tidx, hit_axis_thit,
          hit_axis_thcount, hit_axis_tvcount} = out_data;
endmodule

// File: tb/tb_nearest_hit_reduce.sv
// Drives closest-hit and any-hit instances with one stream and checks both against a ray-level model.
module tb_nearest_hit_reduce;
  localparam int N  = 8;
  localparam int IW = 4;
  localparam logic [31:0] TMIN = 32'h3a83126f;

  typedef struct packed {
    logic [31:0]  t;
    logic [191:0] pay;
    logic [3:0]   idx;
    logic         miss;
    logic [10:0]  hc;
    logic [9:0]   vc;
  } beat_t;

  logic aclk = 1'b0, areset = 1'b1;
  logic [31:0] c_t; logic [191:0] c_pay; logic [IW-1:0] c_idx;
  logic c_miss, c_last, c_valid; logic [10:0] c_hc; logic [9:0] c_vc;
  logic hit_ready;

  logic rdy_c, thit_c, hv_c, err_c, rdy_a, thit_a, hv_a, err_a;
  logic [191:0] hd_c, hd_a; logic [31:0] tt_c, tt_a; logic [IW-1:0] idx_c, idx_a;
  logic [10:0] hc_c, hc_a; logic [9:0] vc_c, vc_a;
  logic [255:0] res_c, res_a;

  beat_t ray[$];
  logic [255:0] exp_c[$], exp_a[$];
  int total = 0, bad = 0, bp_cnt = 0;
  bit err_exp = 0, rand_bp = 0, started = 0;
  logic [31:0] last_t = 32'h3f800000;

  always #5 aclk = ~aclk;

  nearest_hit_reduce #(.NUM_OBJS(N), .ANY_HIT(1'b0)) u_cls (
    .aclk(aclk), .areset(areset), .cand_axis_tdata(c_t), .cand_axis_tpayload(c_pay),
    .cand_axis_tidx(c_idx), .cand_axis_tmiss(c_miss), .cand_axis_tlast(c_last),
    .cand_axis_thcount(c_hc), .cand_axis_tvcount(c_vc), .cand_axis_tvalid(c_valid),
    .cand_axis_tready(rdy_c), .hit_axis_tdata(hd_c), .hit_axis_tt(tt_c), .hit_axis_tidx(idx_c),
    .hit_axis_thit(thit_c), .hit_axis_thcount(hc_c), .hit_axis_tvcount(vc_c),
    .hit_axis_tvalid(hv_c), .hit_axis_tready(hit_ready), .err_overlong(err_c));

  nearest_hit_reduce #(.NUM_OBJS(N), .ANY_HIT(1'b1)) u_any (
    .aclk(aclk), .areset(areset), .cand_axis_tdata(c_t), .cand_axis_tpayload(c_pay),
    .cand_axis_tidx(c_idx), .cand_axis_tmiss(c_miss), .cand_axis_tlast(c_last),
    .cand_axis_thcount(c_hc), .cand_axis_tvcount(c_vc), .cand_axis_tvalid(c_valid),
    .cand_axis_tready(rdy_a), .hit_axis_tdata(hd_a), .hit_axis_tt(tt_a), .hit_axis_tidx(idx_a),
    .hit_axis_thit(thit_a), .hit_axis_thcount(hc_a), .hit_axis_tvcount(vc_a),
    .hit_axis_tvalid(hv_a), .hit_axis_tready(hit_ready), .err_overlong(err_a));

  assign res_c = {6'b0, thit_c, idx_c, tt_c, hd_c, hc_c, vc_c};
  assign res_a = {6'b0, thit_a, idx_a, tt_a, hd_a, hc_a, vc_a};

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Decode an IEEE single into a real value; fin=0 for Inf/NaN.
  function automatic void f2r(input logic [31:0] b, output real v, output bit fin);
    int  e = int'(b[30:23]);
    real m = real'(b[22:0]) / 8388608.0;
    fin = (e != 255);
    if (e == 0) v = m * (2.0 ** (-126));
    else        v = (1.0 + m) * (2.0 ** (e - 127));
    if (b[31]) v = -v;
  endfunction

  function automatic logic [255:0] ref_result(input bit any);
    real tmin, fmax, best, r;
    bit fin, found, good;
    int w;
    beat_t lb;
    f2r(TMIN, tmin, fin);
    f2r(32'h7f7fffff, fmax, fin);
    best = fmax; found = 0; w = 0;
    foreach (ray[i]) begin
      f2r(ray[i].t, r, fin);
      good = !ray[i].miss && (ray[i].idx < N) && fin && (r > tmin);
      if (good && (any ? !found : (r < best))) begin
        found = 1; best = r; w = i;
      end
    end
    lb = ray[ray.size()-1];
    if (found)
      return {6'b0, 1'b1, ray[w].idx, ray[w].t, ray[w].pay, lb.hc, lb.vc};
    return {6'b0, 1'b0, 4'(N), 32'h7f7fffff, 192'b0, lb.hc, lb.vc};
  endfunction

  // Output-side backpressure, changed away from both clock edges.
  always @(posedge aclk) begin
    #2;
    if (bp_cnt > 0) begin
      hit_ready = 1'b0;
      bp_cnt--;
    end else begin
      hit_ready = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Every visible result must match the head of the scoreboard, including while stalled.
  always @(negedge aclk) begin
    if (started && !areset) begin
      chk("rdy_eq", {255'b0, rdy_a}, {255'b0, rdy_c});
      if (hv_c) begin
        if (exp_c.size() == 0) chk("spurious_c", 256'd1, 256'd0);
        else begin
          chk("out_cls", res_c, exp_c[0]);
          if (hit_ready) void'(exp_c.pop_front());
        end
      end
      if (hv_a) begin
        if (exp_a.size() == 0) chk("spurious_a", 256'd1, 256'd0);
        else begin
          chk("out_any", res_a, exp_a[0]);
          if (hit_ready) void'(exp_a.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [31:0] t, input logic [3:0] idx, input bit miss, input bit last);
    beat_t b;
    bit ok = 0;
    b.t = t; b.idx = idx; b.miss = miss;
    b.pay = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b.hc = 11'($urandom); b.vc = 10'($urandom);
    c_t = t; c_idx = idx; c_miss = miss; c_last = last; c_pay = b.pay; c_hc = b.hc; c_vc = b.vc;
    c_valid = 1'b1;
    for (int n = 0; n < 300 && !ok; n++) begin
      #4;
      ok = rdy_c;
      @(posedge aclk);
      if (!ok) @(negedge aclk);
    end
    if (!ok) begin
      chk("send_timeout", 256'd0, 256'd1);
      c_valid = 1'b0;
      return;
    end
    ray.push_back(b);
    if (last || ray.size() == N) begin
      if (!last) err_exp = 1;
      exp_c.push_back(ref_result(0));
      exp_a.push_back(ref_result(1));
      ray.delete();
    end
    @(negedge aclk);
    c_valid = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    bp_cnt = 0;
    @(negedge aclk);
    ray.delete(); exp_c.delete(); exp_a.delete(); err_exp = 0;
    chk("rst_valid", {255'b0, hv_c}, 256'd0);
    chk("rst_err", {255'b0, err_c}, 256'd0);
    @(negedge aclk);
    areset = 1'b0;
    chk("rst_rdy", {255'b0, rdy_c}, 256'd1);
  endtask

  function automatic logic [31:0] rand_t();
    case ($urandom_range(0, 7))
      0: return 32'h80000000 | 32'($urandom_range(0, 32'h7f7fffff));
      1: return 32'h7f800000 | (32'($urandom_range(0, 1)) << 22);
      2: return 32'h3a800000 + 32'($urandom_range(0, 32'h00100000));
      3: return last_t;
      default: return 32'h3c000000 + 32'($urandom_range(0, 32'h06ffffff));
    endcase
  endfunction

  initial begin
    logic [31:0] t;
    int len;
    c_valid = 0; c_t = 0; c_pay = 0; c_idx = 0; c_miss = 0; c_last = 0; c_hc = 0; c_vc = 0;
    hit_ready = 1'b1;
    repeat (3) @(negedge aclk);
    chk("reset_valid", {255'b0, hv_c}, 256'd0);
    chk("reset_data", res_c, 256'd0);
    chk("reset_err", {255'b0, err_c}, 256'd0);
    chk("reset_valid_any", {255'b0, hv_a}, 256'd0);
    areset = 1'b0;
    started = 1;
    chk("reset_rdy", {255'b0, rdy_c}, 256'd1);

    // closest of {4,2,3}
    send(32'h40800000, 0, 0, 0); send(32'h40000000, 1, 0, 0); send(32'h40400000, 2, 0, 1);
    chk("cls_lat", {255'b0, hv_c}, 256'd1);
    chk("cls_idx", 256'(idx_c), 256'd1);
    chk("cls_t", 256'(tt_c), 256'h40000000);
    chk("cls_hit", {255'b0, thit_c}, 256'd1);
    repeat (2) @(negedge aclk);

    // filtered candidates only
    send(32'hbf800000, 0, 0, 0); send(32'h3a03126f, 1, 0, 0); send(32'h7f800000, 2, 0, 0);
    send(32'h7fc00000, 3, 0, 0); send(32'h3f800000, 4, 1, 1);
    chk("flt_hit", {255'b0, thit_c}, 256'd0);
    chk("flt_idx", 256'(idx_c), 256'(N));
    chk("flt_t", 256'(tt_c), 256'h7f7fffff);
    chk("flt_data", 256'(hd_c), 256'd0);

    // t exactly at epsilon and out-of-range index
    send(TMIN, 0, 0, 0); send(32'h3f800000, 4'(N), 0, 1);
    chk("edge_hit", {255'b0, thit_c}, 256'd0);

    // equal t keeps the earlier beat
    send(32'h40000000, 2, 0, 0); send(32'h40000000, 5, 0, 1);
    chk("tie_idx", 256'(idx_c), 256'd2);

    // any-hit takes the first valid candidate
    send(32'h40c00000, 3, 0, 0); send(32'h40000000, 7, 0, 1);
    chk("any_idx", 256'(idx_a), 256'd3);
    chk("any_t", 256'(tt_a), 256'h40c00000);
    chk("cls_idx2", 256'(idx_c), 256'd7);

    // backpressure across two rays
    @(negedge aclk);
    bp_cnt = 5;
    send(32'h41000000, 1, 0, 0); send(32'h40800000, 2, 0, 1);
    chk("bp_rdy_low", {255'b0, rdy_c}, 256'd0);
    chk("bp_valid", {255'b0, hv_c}, 256'd1);
    send(32'h3f800000, 3, 0, 0); send(32'h40000000, 4, 0, 1);
    @(negedge aclk);

    // overlong ray: the N-th beat closes it
    chk("err_pre", {255'b0, err_c}, 256'd0);
    for (int i = 0; i < N; i++) send(32'h40000000 + (32'(7 - i) << 16), 4'(i), 0, 0);
    chk("ovl_valid", {255'b0, hv_c}, 256'd1);
    chk("ovl_err", {255'b0, err_c}, 256'd1);
    chk("ovl_idx", 256'(idx_c), 256'd7);
    send(32'h3f800000, 5, 0, 1);
    chk("ovl_next_idx", 256'(idx_c), 256'd5);

    // reset with a stalled result, then mid-ray
    @(negedge aclk);
    bp_cnt = 20;
    send(32'h3f800000, 1, 0, 1);
    do_reset();
    send(32'h40000000, 0, 0, 0); send(32'h40400000, 1, 0, 0);
    do_reset();
    send(32'h3f800000, 5, 0, 1);
    chk("post_rst_idx", 256'(idx_c), 256'd5);
    chk("post_rst_hit", {255'b0, thit_c}, 256'd1);
    @(negedge aclk);
    chk("no_stale", {255'b0, hv_c}, 256'd0);

    // randomized rays, some overlong, with random stalls
    rand_bp = 1;
    for (int r = 0; r < 250; r++) begin
      len = $urandom_range(1, 10);
      for (int j = 0; j < len; j++) begin
        t = rand_t();
        last_t = t;
        send(t, 4'($urandom_range(0, N)), ($urandom_range(0, 7) == 0), (j == len - 1));
        if ($urandom_range(0, 3) == 0) @(negedge aclk);
      end
    end
    rand_bp = 0;
    for (int n = 0; n < 200 && (exp_c.size() != 0 || exp_a.size() != 0); n++) @(negedge aclk);
    chk("drain", 256'(exp_c.size() + exp_a.size()), 256'd0);
    chk("err_final", {255'b0, err_c}, {255'b0, err_exp});
    chk("err_final_any", {255'b0, err_a}, {255'b0, err_exp});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
